// File: rtl/axi_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_arbiter_if
// AXI3-style bus between the arbiter and a single AXI slave.
//
// Signal groups:
//   read address   : arid, araddr, arlen, arsize, arburst, arlock, arcache,
//                    arprot, arvalid / arready
//   read data      : rid, rdata, rresp, rlast, rvalid / rready
//   write address  : awid, awaddr, awlen, awsize, awburst, awlock, awcache,
//                    awprot, awvalid / awready
//   write data     : wid, wdata, wstrb, wlast, wvalid / wready
//   write response : bid, bresp, bvalid / bready
//
// Modports:
//   master : the arbiter side (drives addresses, write data and the ready
//            signals of the response channels)
//   slave  : the memory / interconnect side
// ---------------------------------------------------------------------------
interface axi_arbiter_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/axi_arbiter.sv
// ---------------------------------------------------------------------------
// axi_arbiter
// Funnels an instruction-fetch read port and a data read/write port onto one
// AXI master interface, one single-beat transaction per channel at a time.
//
// Ports:
//   clock, reset           : system clock, synchronous active-high reset
//   inst_rreq/raddr        : instruction read request and address
//   inst_rack/rvalid/rdata : accept pulse, response pulse, read data
//   data_rreq/raddr/rsize  : data read request, address, AXI size code
//   data_rack/rvalid/rdata : accept pulse, response pulse, read data
//   data_wreq/waddr/wsize/wstrb/wdata : data write request and payload
//   data_wack/wdone        : write accept pulse, write complete pulse
//   bus                    : AXI master side (axi_arbiter_if.master)
//
// Reads and writes run in two independent FSMs. Read requests are arbitrated
// round-robin; a data read that hits the word of an in-flight write is held
// off until that write has completed so it cannot return stale data.
// ---------------------------------------------------------------------------
module axi_arbiter (
   input  logic        clock,
   input  logic        reset,

   input  logic        inst_rreq,
   input  logic [31:0] inst_raddr,
   output logic        inst_rack,
   output logic        inst_rvalid,
   output logic [31:0] inst_rdata,

   input  logic        data_rreq,
   input  logic [31:0] data_raddr,
   input  logic [2:0]  data_rsize,
   output logic        data_rack,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,

   input  logic        data_wreq,
   input  logic [31:0] data_waddr,
   input  logic [2:0]  data_wsize,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_wack,
   output logic        data_wdone,

   axi_arbiter_if.master bus
);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_B} w_state_t;

   r_state_t    r_state;
   r_state_t    r_state_next;
   logic [31:0] r_addr;
   logic [2:0]  r_size;
   logic        r_id;
   logic        rr_data_first;
   logic        resp_valid;
   logic [31:0] resp_data;

   logic        data_hazard;
   logic        data_eligible;
   logic        grant_inst;
   logic        grant_data;
   logic        r_fire;

   w_state_t    w_state;
   w_state_t    w_state_next;
   logic [31:0] w_addr;
   logic [2:0]  w_size;
   logic [3:0]  w_strb;
   logic [31:0] w_data;
   logic        aw_done;
   logic        w_done;
   logic        aw_complete;
   logic        w_complete;

   logic        unused_bus;

   // A data read is held back while a write to the same 32-bit word is still
   // in flight; instruction fetches never alias writes so they are never
   // blocked. When both reads compete, rr_data_first picks the one that lost
   // last time.
   always_comb begin
      data_hazard   = (w_state != W_IDLE) && (data_raddr[31:2] == w_addr[31:2]);
      data_eligible = data_rreq && !data_hazard;
      grant_inst    = 1'b0;
      grant_data    = 1'b0;
      if (r_state == R_IDLE) begin
         if (inst_rreq && data_eligible) begin
            grant_data = rr_data_first;
            grant_inst = !rr_data_first;
         end else begin
            grant_inst = inst_rreq;
            grant_data = data_eligible;
         end
      end
   end

   assign r_fire = (r_state == R_R) && bus.rvalid;

   // Read FSM next state: accept, address phase, wait for the single beat.
   always_comb begin
      r_state_next = r_state;
      case (r_state)
         R_IDLE:  if (grant_inst || grant_data) r_state_next = R_AR;
         R_AR:    if (bus.arready) r_state_next = R_R;
         R_R:     if (bus.rvalid) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   // Read state register. The response is registered so the requester sees
   // a clean one-cycle pulse with stable data, one cycle after the R beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= R_IDLE;
         r_addr        <= '0;
         r_size        <= '0;
         r_id          <= 1'b0;
         rr_data_first <= 1'b0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
      end else begin
         r_state    <= r_state_next;
         resp_valid <= r_fire;
         if (r_fire) begin
            resp_data <= bus.rdata;
         end
         if (grant_inst) begin
            r_addr        <= inst_raddr;
            r_size        <= 3'd2;
            r_id          <= 1'b0;
            rr_data_first <= 1'b1;
         end else if (grant_data) begin
            r_addr        <= data_raddr;
            r_size        <= data_rsize;
            r_id          <= 1'b1;
            rr_data_first <= 1'b0;
         end
      end
   end

   // Address and data channels each complete on their own handshake; the
   // done flags remember which one has already gone so it is not re-sent.
   assign aw_complete = aw_done || bus.awready;
   assign w_complete  = w_done || bus.wready;

   // Write FSM next state.
   always_comb begin
      w_state_next = w_state;
      case (w_state)
         W_IDLE:  if (data_wreq) w_state_next = W_SEND;
         W_SEND:  if (aw_complete && w_complete) w_state_next = W_B;
         W_B:     if (bus.bvalid) w_state_next = W_IDLE;
         default: w_state_next = W_IDLE;
      endcase
   end

   // Write state register and payload latch.
   always_ff @(posedge clock) begin
      if (reset) begin
         w_state <= W_IDLE;
         w_addr  <= '0;
         w_size  <= '0;
         w_strb  <= '0;
         w_data  <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         w_state <= w_state_next;
         aw_done <= (w_state == W_SEND) && (w_state_next == W_SEND) && aw_complete;
         w_done  <= (w_state == W_SEND) && (w_state_next == W_SEND) && w_complete;
         if ((w_state == W_IDLE) && data_wreq) begin
            w_addr <= data_waddr;
            w_size <= data_wsize;
            w_strb <= data_wstrb;
            w_data <= data_wdata;
         end
      end
   end

   // Handshake outputs are forced low during reset because the state
   // registers only clear on the first reset edge.
   assign inst_rack   = !reset && grant_inst;
   assign data_rack   = !reset && grant_data;
   assign inst_rvalid = !reset && resp_valid && !r_id;
   assign data_rvalid = !reset && resp_valid && r_id;
   assign inst_rdata  = resp_data;
   assign data_rdata  = resp_data;

   assign data_wack   = !reset && (w_state == W_IDLE) && data_wreq;
   assign data_wdone  = !reset && (w_state == W_B) && bus.bvalid;

   assign bus.arid    = {3'b000, r_id};
   assign bus.araddr  = r_addr;
   assign bus.arlen   = 4'd0;
   assign bus.arsize  = r_size;
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'd0;
   assign bus.arprot  = 3'd0;
   assign bus.arvalid = !reset && (r_state == R_AR);
   assign bus.rready  = !reset && (r_state == R_R);

   assign bus.awid    = 4'd1;
   assign bus.awaddr  = w_addr;
   assign bus.awlen   = 4'd0;
   assign bus.awsize  = w_size;
   assign bus.awburst = 2'b01;
   assign bus.awlock  = 2'b00;
   assign bus.awcache = 4'd0;
   assign bus.awprot  = 3'd0;
   assign bus.awvalid = !reset && (w_state == W_SEND) && !aw_done;

   assign bus.wid     = 4'd1;
   assign bus.wdata   = w_data;
   assign bus.wstrb   = w_strb;
   assign bus.wlast   = 1'b1;
   assign bus.wvalid  = !reset && (w_state == W_SEND) && !w_done;
   assign bus.bready  = !reset && (w_state == W_B);

   // Only single-beat transactions with fixed IDs are issued, so response
   // IDs, status and rlast carry no information this block acts on.
   assign unused_bus = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

endmodule
